aes_out_framer: RTL

- Downstream stage of the AES-128 core. Tracks each launch through the core's fixed pipeline latency and captures the 128-bit result when it emerges.
- Buffers results in a small FIFO and streams each one out as four 32-bit words over a valid/ready interface for a 32-bit host bus or UART bridge.
- Flags dropped results instead of stalling, because the core pipeline cannot be back-pressured.

---
 rtl/aes_out_framer_if.sv | 22 ++
 rtl/aes_out_framer.sv | 117 +++++++++++
 2 files changed

// File: rtl/aes_out_framer_if.sv
// 32-bit word stream from the AES result framer to a host bus or UART bridge.
// master drives m_data/m_valid/m_last; slave drives m_ready.
interface aes_out_framer_if;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/aes_out_framer.sv
// Tracks AES core launches, captures 128-bit results into a FIFO and
// streams each as four 32-bit words, MSW first.
// Ports: clk, rst (async, active-low), in_valid (launch strobe),
//   core_out (128-bit core result), m (word stream, master side),
//   count (FIFO occupancy), overflow (sticky: a result was dropped).
module aes_out_framer #(
  parameter  int LATENCY = 21,
  parameter  int DEPTH   = 4,
  localparam int CW      = $clog2(DEPTH + 1),
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [127:0]        core_out,
  aes_out_framer_if.master    m,
  output logic [CW-1:0]       count,
  output logic                overflow
);

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_e              state_q, state_d;
  logic [LATENCY-1:0]  vld_q, vld_d;
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d;
  logic [1:0]          idx_q, idx_d;
  logic                ovf_q;
  logic [127:0]        mem_q [DEPTH];

  logic                tap;
  logic                send;
  logic                xfer;
  logic                pop;
  logic                wr;
  logic [127:0]        head;
  logic [31:0]         word;

  // Truncating cast keeps the shift legal for LATENCY == 1.
  assign vld_d = LATENCY'({vld_q, in_valid});
  assign tap   = vld_q[LATENCY-1];

  assign send = (state_q == SEND);
  assign xfer = send && m.m_ready;
  assign pop  = xfer && (idx_q == 2'd3);
  // A full FIFO still takes the result when the head leaves this cycle.
  assign wr   = tap && ((count_q != FULL) || pop);

  assign count_d = count_q + CW'(wr) - CW'(pop);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if ((count_q != '0) || wr) state_d = SEND;
      end
      SEND: begin
        if (xfer) idx_d = idx_q + 2'd1;
        if (pop && (count_d == '0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    word = '0;
    unique case (idx_q)
      2'd0: word = head[127:96];
      2'd1: word = head[95:64];
      2'd2: word = head[63:32];
      2'd3: word = head[31:0];
      default: word = '0;
    endcase
  end

  // Gated by state so reset forces the bus to zero even though the
  // storage array itself is not reset.
  assign m.m_valid = send;
  assign m.m_data  = send ? word : '0;
  assign m.m_last  = send && (idx_q == 2'd3);

  assign count    = count_q;
  assign overflow = ovf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      if (wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (tap && !wr) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= core_out;
  end

endmodule
